// File: rtl/commit_cu.sv
// In-order commit stage. It retires the ROB head to the RF and register status, releases stores,
// counts retirements, and turns mispredicts and exceptions into a one-cycle flush with a redirect.
package commit_cu_pkg;
  localparam int XLEN        = 32;
  localparam int REG_IDX_LEN = 5;
  localparam int ROB_IDX_W   = 4;
  localparam int EXCEPT_W    = 4;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [EXCEPT_W-1:0]  except_t;

  typedef struct packed {
    logic                   res_ready;
    logic [XLEN-1:0]        res_value;
    logic [REG_IDX_LEN-1:0] rd_idx;
    logic                   rd_upd;
    logic                   is_store;
    logic                   is_jump;
    logic                   mispredicted;
    logic [XLEN-1:0]        target;
    logic                   except_raised;
    except_t                except_code;
    logic [XLEN-1:0]        instr_pc;
  } rob_entry_t;
endpackage

module commit_cu
  import commit_cu_pkg::*;
#(
  parameter logic [XLEN-1:0] MTVEC_ADDR = 32'h0000_0100,
  parameter int              INSTRET_W  = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   comm_valid_i,
  output logic                   comm_ready_o,
  input  rob_entry_t             comm_data_i,
  input  rob_idx_t               comm_head_idx_i,
  output logic                   rf_we_o,
  output logic [REG_IDX_LEN-1:0] rf_idx_o,
  output logic [XLEN-1:0]        rf_data_o,
  output logic                   rs_clr_o,
  output rob_idx_t               rs_rob_idx_o,
  output logic                   sb_valid_o,
  input  logic                   sb_ready_i,
  output logic                   flush_o,
  output logic                   fe_redirect_o,
  output logic [XLEN-1:0]        fe_pc_o,
  output logic                   trap_o,
  output except_t                trap_cause_o,
  output logic [XLEN-1:0]        trap_pc_o,
  output logic [INSTRET_W-1:0]   instret_o
);

  typedef enum logic [1:0] {S_COMMIT, S_MISPRED, S_TRAP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] target_q;
  logic            ready_head, pop;
  logic            take_trap, take_mispred;

  assign ready_head = comm_valid_i & comm_data_i.res_ready;
  assign pop        = comm_valid_i & comm_ready_o;

  // Outputs are gated by rst_i so a reset during S_TRAP/S_MISPRED emits no pulse.
  always_comb begin
    state_nxt     = state;
    comm_ready_o  = 1'b0;
    rf_we_o       = 1'b0;
    rf_idx_o      = '0;
    rf_data_o     = '0;
    rs_clr_o      = 1'b0;
    rs_rob_idx_o  = '0;
    sb_valid_o    = 1'b0;
    flush_o       = 1'b0;
    fe_redirect_o = 1'b0;
    fe_pc_o       = '0;
    trap_o        = 1'b0;
    take_trap     = 1'b0;
    take_mispred  = 1'b0;
    if (!rst_i) begin
      case (state)
        S_COMMIT: if (ready_head) begin
          if (comm_data_i.except_raised) begin
            take_trap = 1'b1;
            state_nxt = S_TRAP;
          end else if (comm_data_i.is_store) begin
            sb_valid_o   = 1'b1;
            comm_ready_o = sb_ready_i;
          end else begin
            comm_ready_o = 1'b1;
            rf_we_o      = comm_data_i.rd_upd & (comm_data_i.rd_idx != '0);
            rf_idx_o     = comm_data_i.rd_idx;
            rf_data_o    = comm_data_i.res_value;
            rs_clr_o     = comm_data_i.rd_upd;
            rs_rob_idx_o = comm_head_idx_i;
            if (comm_data_i.is_jump & comm_data_i.mispredicted) begin
              take_mispred = 1'b1;
              state_nxt    = S_MISPRED;
            end
          end
        end
        S_MISPRED: begin
          flush_o       = 1'b1;
          fe_redirect_o = 1'b1;
          fe_pc_o       = target_q;
          state_nxt     = S_COMMIT;
        end
        S_TRAP: begin
          flush_o       = 1'b1;
          trap_o        = 1'b1;
          fe_redirect_o = 1'b1;
          fe_pc_o       = MTVEC_ADDR;
          state_nxt     = S_COMMIT;
        end
        default: state_nxt = S_COMMIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_COMMIT;
      target_q     <= '0;
      trap_cause_o <= '0;
      trap_pc_o    <= '0;
      instret_o    <= '0;
    end else begin
      state <= state_nxt;
      if (pop)          instret_o <= instret_o + INSTRET_W'(1);
      if (take_mispred) target_q  <= comm_data_i.target;
      if (take_trap) begin
        trap_cause_o <= comm_data_i.except_code;
        trap_pc_o    <= comm_data_i.instr_pc;
      end
    end
  end

endmodule
